multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Moore-style control FSM that sequences the multicycle MIPS datapath. It issues one control vector per cycle, covering fetch, decode, execute, memory and writeback. It decodes opc/func from the instruction register and uses the ALU zero flag for conditional branches. It sits beside the datapath and drives every one of its control inputs.

Parameters:
None. The state register is 4 bits with fixed encoding S0..S13 = 0..13.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
opc  input  6  IR[31:26]
func  input  6  IR[5:0]
zero  input  1  ALU result == 0
PCLoad  output  1  PC register load
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read
MemWrite  output  1  memory write
IRWrite  output  1  IR load
RegDst  output  1  write register: 0 = rt, 1 = rd
JalSig1  output  1  write register forced to 31
MemToReg  output  1  write data: 0 = MDR, 1 = ALUOut
JalSig2  output  1  write data = PC
RegWrite  output  1  register file write
ALUSrcA  output  1  ALU A: 0 = PC, 1 = A reg
ALUSrcB  output  2  ALU B: 0 = B reg, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
ALUOperation  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
PCSrc  output  2  PC source: 0 = ALU res, 1 = jump address, 2 = ALUOut, 3 = A reg

Behaviour:
- Reset: while rst = 0, state is S0 and all outputs are forced to 0. The first active edge after release executes S0.
- Outputs are combinational from the state. The only exception is PCLoad in S8, which also depends on opc and zero. Any output not listed for a state is 0.
- S0 FETCH: MemRead, IRWrite, IorD = 0, ALUSrcA = 0, ALUSrcB = 1, ADD, PCSrc = 0, PCLoad. Next state S1.
- S1 DECODE: ALUSrcA = 0, ALUSrcB = 3, ADD (computes the branch target). Next state by decode:
  - opc 000000 with func 001000 (jr) -> S13.
  - opc 000000 with func in {100000, 100010, 100100, 100101, 101010} -> S6.
  - opc 000000 with any other func -> S0 (NOP).
  - lw 100011 or sw 101011 -> S2.
  - addi 001000 or slti 001010 -> S11.
  - beq 000100 or bne 000101 -> S8.
  - j 000010 -> S9.
  - jal 000011 -> S10.
  - Any other opcode -> S0 (NOP; PC already advanced).
- S2 MEMADR: ALUSrcA = 1, ALUSrcB = 2, ADD. Next state S3 for lw, S5 for sw.
- S3 MEMRD: MemRead, IorD = 1. Next state S4.
- S4 LWWB: RegDst = 0, MemToReg = 0, RegWrite. Next state S0.
- S5 MEMWR: MemWrite, IorD = 1. Next state S0.
- S6 REXEC: ALUSrcA = 1, ALUSrcB = 0. ALUOperation by func: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Next state S7.
- S7 RWB: RegDst = 1, MemToReg = 1, RegWrite. Next state S0.
- S8 BRANCH: ALUSrcA = 1, ALUSrcB = 0, SUB, PCSrc = 2. PCLoad = zero for beq, ~zero for bne. Next state S0.
- S9 JUMP: PCSrc = 1, PCLoad. Next state S0.
- S10 JAL: JalSig1, JalSig2, RegWrite, PCSrc = 1, PCLoad. Next state S0.
  - On the same edge, the register file captures the old PC (already PC+4) and the PC loads the jump target.
- S11 IEXEC: ALUSrcA = 1, ALUSrcB = 2. ADD for addi, SLT for slti. Next state S12.
- S12 IWB: RegDst = 0, MemToReg = 1, RegWrite. Next state S0.
- S13 JR: PCSrc = 3, PCLoad. Next state S0. The A register holds rs, which was latched at the end of S1.
- Cycles per instruction: lw 5; sw, R-type, addi, slti 4; beq, bne, j, jal, jr 3; NOP/illegal 2.
- MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.
- Unreachable encodings 14 and 15 go to S0 on the next edge with all outputs 0.
- Reset asserted mid-instruction: state goes to S0 immediately. Any memory or register write in progress is dropped in that same cycle, because outputs are forced to 0.

Test Plan:
- Reset: hold rst = 0 for 3 cycles, then release -> all outputs 0 during reset. First cycle after release shows MemRead = IRWrite = PCLoad = 1, ALUSrcB = 01, ALUOperation = 010.
- lw (opc 100011) -> states S0, S1, S2, S3, S4. In S3: IorD = 1, MemRead = 1. In S4: RegWrite = 1, MemToReg = 0, RegDst = 0. Back in S0 at cycle 6.
- R-type sub (opc 000000, func 100010) -> S6 drives ALUOperation = 110, ALUSrcA = 1, ALUSrcB = 00. S7 drives RegDst = 1, MemToReg = 1, RegWrite = 1.
- beq with zero = 1 -> PCLoad = 1, PCSrc = 10 in S8. Repeat with zero = 0 -> PCLoad = 0. bne with zero = 0 -> PCLoad = 1.
- jal (opc 000011) -> S10 drives JalSig1 = JalSig2 = RegWrite = PCLoad = 1, PCSrc = 01. jr (func 001000) -> S13 drives PCSrc = 11, PCLoad = 1, RegWrite = 0.
- Illegal opc 111111 -> S0, S1, S0 with no RegWrite or MemWrite. Assert rst = 0 during S5 of sw -> MemWrite drops to 0 immediately, and the state is S0 after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath: one control vector per state,
// next state decoded from opc/func, and PCLoad in BRANCH qualified by the ALU zero flag.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCLoad,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       JalSig1,
  output logic       MemToReg,
  output logic       JalSig2,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_LWWB   = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_JAL    = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state, next_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  assign dbg_state = state;

  always_comb begin
    next_state   = S_FETCH;
    PCLoad       = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    JalSig1      = 1'b0;
    MemToReg     = 1'b0;
    JalSig2      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'd0;
    ALUOperation = ALU_AND;
    PCSrc        = 2'd0;
    // Outputs stay all-zero while reset is held so an in-flight write is dropped at once.
    if (rst) begin
      case (state)
        S_FETCH: begin
          MemRead      = 1'b1;
          IRWrite      = 1'b1;
          ALUSrcB      = 2'd1;
          ALUOperation = ALU_ADD;
          PCLoad       = 1'b1;
          next_state   = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB      = 2'd3;
          ALUOperation = ALU_ADD;
          case (opc)
            OP_RTYPE: begin
              if (func == FN_JR)
                next_state = S_JR;
              else if (func inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
                next_state = S_REXEC;
              else
                next_state = S_FETCH;
            end
            OP_LW, OP_SW:     next_state = S_MEMADR;
            OP_ADDI, OP_SLTI: next_state = S_IEXEC;
            OP_BEQ, OP_BNE:   next_state = S_BRANCH;
            OP_J:             next_state = S_JUMP;
            OP_JAL:           next_state = S_JAL;
            default:          next_state = S_FETCH;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'd2;
          ALUOperation = ALU_ADD;
          next_state   = (opc == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemRead    = 1'b1;
          IorD       = 1'b1;
          next_state = S_LWWB;
        end
        S_LWWB: begin
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          next_state = S_FETCH;
        end
        S_REXEC: begin
          ALUSrcA = 1'b1;
          case (func)
            FN_SUB:  ALUOperation = ALU_SUB;
            FN_AND:  ALUOperation = ALU_AND;
            FN_OR:   ALUOperation = ALU_OR;
            FN_SLT:  ALUOperation = ALU_SLT;
            default: ALUOperation = ALU_ADD;
          endcase
          next_state = S_RWB;
        end
        S_RWB: begin
          RegDst     = 1'b1;
          MemToReg   = 1'b1;
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA      = 1'b1;
          ALUOperation = ALU_SUB;
          PCSrc        = 2'd2;
          PCLoad       = (opc == OP_BNE) ? ~zero : zero;
          next_state   = S_FETCH;
        end
        S_JUMP: begin
          PCSrc      = 2'd1;
          PCLoad     = 1'b1;
          next_state = S_FETCH;
        end
        S_JAL: begin
          // Register file takes the already-advanced PC on the same edge the PC takes the target.
          JalSig1    = 1'b1;
          JalSig2    = 1'b1;
          RegWrite   = 1'b1;
          PCSrc      = 2'd1;
          PCLoad     = 1'b1;
          next_state = S_FETCH;
        end
        S_IEXEC: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'd2;
          ALUOperation = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
          next_state   = S_IWB;
        end
        S_IWB: begin
          MemToReg   = 1'b1;
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_JR: begin
          PCSrc      = 2'd3;
          PCLoad     = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction control-vector model, a table of
// directed instructions with hand-written CPIs, random instructions, and reset corners.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opc;
  logic [5:0] func;
  logic       zero;
  logic       PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1;
  logic       MemToReg, JalSig2, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOperation;
  logic [1:0] PCSrc;
  logic [3:0] dbg_state;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
    .PCLoad(PCLoad), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .JalSig1(JalSig1), .MemToReg(MemToReg),
    .JalSig2(JalSig2), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOperation(ALUOperation), .PCSrc(PCSrc), .dbg_state(dbg_state)
  );

  localparam int W = 22;

  // Observed vector layout: {state, 10 flags, ALUSrcA, ALUSrcB, ALUOperation, PCSrc}
  logic [W-1:0] obs;
  assign obs = {dbg_state, PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1,
                MemToReg, JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc};

  localparam logic [9:0] PCL  = 10'h200;
  localparam logic [9:0] IORD = 10'h100;
  localparam logic [9:0] MRD  = 10'h080;
  localparam logic [9:0] MWR  = 10'h040;
  localparam logic [9:0] IRW  = 10'h020;
  localparam logic [9:0] RDST = 10'h010;
  localparam logic [9:0] JAL1 = 10'h008;
  localparam logic [9:0] M2R  = 10'h004;
  localparam logic [9:0] JAL2 = 10'h002;
  localparam logic [9:0] RWR  = 10'h001;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;

  typedef struct {
    logic [5:0] opc;
    logic [5:0] func;
    logic       zero;
    int         cpi;
    string      name;
  } vec_t;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int st, input logic [9:0] flags, input logic srca,
                                      input logic [1:0] srcb, input logic [2:0] aluop,
                                      input logic [1:0] pcsrc);
    logic [3:0] s;
    s = st[3:0];
    return {s, flags, srca, srcb, aluop, pcsrc};
  endfunction

  // Reference: the list of control vectors an instruction produces, one per cycle.
  task automatic model_push(input logic [5:0] o, input logic [5:0] f, input logic z);
    exp_q.push_back(mk(0, MRD | IRW | PCL, 1'b0, 2'd1, A_ADD, 2'd0));
    exp_q.push_back(mk(1, 10'h0, 1'b0, 2'd3, A_ADD, 2'd0));
    if (o == 6'h00) begin
      if (f == 6'h08) exp_q.push_back(mk(13, PCL, 1'b0, 2'd0, A_AND, 2'd3));
      else if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a) begin
        logic [2:0] op;
        op = (f == 6'h20) ? A_ADD : (f == 6'h22) ? A_SUB : (f == 6'h24) ? A_AND :
             (f == 6'h25) ? A_OR : A_SLT;
        exp_q.push_back(mk(6, 10'h0, 1'b1, 2'd0, op, 2'd0));
        exp_q.push_back(mk(7, RDST | M2R | RWR, 1'b0, 2'd0, A_AND, 2'd0));
      end
    end else if (o == 6'h23) begin
      exp_q.push_back(mk(2, 10'h0, 1'b1, 2'd2, A_ADD, 2'd0));
      exp_q.push_back(mk(3, MRD | IORD, 1'b0, 2'd0, A_AND, 2'd0));
      exp_q.push_back(mk(4, RWR, 1'b0, 2'd0, A_AND, 2'd0));
    end else if (o == 6'h2b) begin
      exp_q.push_back(mk(2, 10'h0, 1'b1, 2'd2, A_ADD, 2'd0));
      exp_q.push_back(mk(5, MWR | IORD, 1'b0, 2'd0, A_AND, 2'd0));
    end else if (o == 6'h08 || o == 6'h0a) begin
      exp_q.push_back(mk(11, 10'h0, 1'b1, 2'd2, (o == 6'h0a) ? A_SLT : A_ADD, 2'd0));
      exp_q.push_back(mk(12, M2R | RWR, 1'b0, 2'd0, A_AND, 2'd0));
    end else if (o == 6'h04 || o == 6'h05) begin
      logic take;
      take = (o == 6'h04) ? z : ~z;
      exp_q.push_back(mk(8, take ? PCL : 10'h0, 1'b1, 2'd0, A_SUB, 2'd2));
    end else if (o == 6'h02) begin
      exp_q.push_back(mk(9, PCL, 1'b0, 2'd0, A_AND, 2'd1));
    end else if (o == 6'h03) begin
      exp_q.push_back(mk(10, PCL | JAL1 | JAL2 | RWR, 1'b0, 2'd0, A_AND, 2'd1));
    end
  endtask

  // Driver + scoreboard: entered at posedge+1 with the DUT in S0, leaves the same way.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int exp_cpi, input string name);
    int cycles;
    int n;
    exp_q.delete();
    opc  = o;
    func = f;
    zero = z;
    model_push(o, f, z);
    n = exp_q.size();
    cycles = 0;
    do begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        check({name, "_vec"}, 32'(obs), 32'(exp_q.pop_front()));
      end else begin
        checks++;
        failures++;
        $display("FAIL %s_extra_cycle actual_state=%0d required_state=0", name, dbg_state);
      end
      cycles++;
      @(posedge clk);
      #1;
    end while (dbg_state != 4'd0 && cycles < 8);
    check({name, "_cpi"}, 32'(cycles), 32'((exp_cpi > 0) ? exp_cpi : n));
  endtask

  vec_t tbl[$];

  initial begin
    checks   = 0;
    failures = 0;
    opc  = 6'h00;
    func = 6'h00;
    zero = 1'b0;
    rst  = 1'b1;

    tbl.push_back('{6'h23, 6'h00, 1'b0, 5, "lw"});
    tbl.push_back('{6'h2b, 6'h00, 1'b0, 4, "sw"});
    tbl.push_back('{6'h00, 6'h20, 1'b0, 4, "add"});
    tbl.push_back('{6'h00, 6'h22, 1'b1, 4, "sub"});
    tbl.push_back('{6'h00, 6'h24, 1'b0, 4, "and"});
    tbl.push_back('{6'h00, 6'h25, 1'b0, 4, "or"});
    tbl.push_back('{6'h00, 6'h2a, 1'b0, 4, "slt"});
    tbl.push_back('{6'h00, 6'h00, 1'b0, 2, "rnop"});
    tbl.push_back('{6'h00, 6'h08, 1'b0, 3, "jr"});
    tbl.push_back('{6'h08, 6'h2a, 1'b0, 4, "addi"});
    tbl.push_back('{6'h0a, 6'h00, 1'b1, 4, "slti"});
    tbl.push_back('{6'h04, 6'h00, 1'b1, 3, "beq_taken"});
    tbl.push_back('{6'h04, 6'h00, 1'b0, 3, "beq_not"});
    tbl.push_back('{6'h05, 6'h00, 1'b0, 3, "bne_taken"});
    tbl.push_back('{6'h05, 6'h00, 1'b1, 3, "bne_not"});
    tbl.push_back('{6'h02, 6'h00, 1'b0, 3, "j"});
    tbl.push_back('{6'h03, 6'h00, 1'b0, 3, "jal"});
    tbl.push_back('{6'h3f, 6'h20, 1'b0, 2, "illegal"});

    // Reset held for three cycles: everything reads zero
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'(obs), 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run_instr(tbl[i].opc, tbl[i].func, tbl[i].zero, tbl[i].cpi, tbl[i].name);

    // Reset asserted while sw is in MEMWR: the write drops in the same cycle
    opc = 6'h2b;
    func = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    check("sw_in_memwr_state", 32'(dbg_state), 32'd5);
    check("sw_memwrite_before_reset", 32'(MemWrite), 32'd1);
    rst = 1'b0;
    #1;
    check("sw_memwrite_dropped", 32'(MemWrite), 32'd0);
    check("sw_reset_outputs", 32'(obs), 32'h0);
    @(posedge clk);
    #1;
    check("sw_reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    run_instr(6'h02, 6'h00, 1'b0, 3, "j_after_reset");

    // Reset asserted during JAL: register write is dropped too
    opc = 6'h03;
    repeat (2) @(posedge clk);
    #1;
    check("jal_in_state", 32'(dbg_state), 32'd10);
    rst = 1'b0;
    #1;
    check("jal_regwrite_dropped", 32'(RegWrite), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_instr(6'h23, 6'h00, 1'b0, 5, "lw_after_reset");

    // Random instruction stream against the model
    for (int i = 0; i < 300; i++) begin
      logic [5:0] o, f;
      logic z;
      logic [5:0] opool[11];
      logic [5:0] fpool[6];
      opool = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h08, 6'h0a, 6'h04, 6'h05, 6'h02, 6'h03};
      fpool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08};
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : opool[$urandom_range(0, 10)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fpool[$urandom_range(0, 5)];
      z = 1'($urandom_range(0, 1));
      run_instr(o, f, z, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
